// File: rtl/lcd_rgb_capture_if.sv
// Pixel-bus bundle between an LCD timing source and the RGB565 capture block.
// The master drives the panel signals; the slave (capture) drives the recovered stream.
interface lcd_rgb_capture_if;
    logic        in_en;
    logic        in_hsync;
    logic        in_vsync;
    logic [4:0]  in_r;
    logic [5:0]  in_g;
    logic [4:0]  in_b;
    logic        out_valid;
    logic        out_sof;
    logic        out_eol;
    logic [9:0]  out_pixelx;
    logic [9:0]  out_pixely;
    logic [15:0] out_rgb;
    logic        out_locked;
    logic        out_err_width;
    logic        out_err_height;
    logic [7:0]  out_err_count;
    logic [15:0] out_frames;

    modport master (
        output in_en, in_hsync, in_vsync, in_r, in_g, in_b,
        input  out_valid, out_sof, out_eol, out_pixelx, out_pixely, out_rgb,
               out_locked, out_err_width, out_err_height, out_err_count, out_frames
    );

    modport slave (
        input  in_en, in_hsync, in_vsync, in_r, in_g, in_b,
        output out_valid, out_sof, out_eol, out_pixelx, out_pixely, out_rgb,
               out_locked, out_err_width, out_err_height, out_err_count, out_frames
    );
endinterface

// File: rtl/lcd_rgb_capture.sv
// Recovers pixel coordinates from a DE/VSYNC RGB565 stream, checks active geometry,
// and reports lock, width/height errors and a good-frame count. Two register stages.
module lcd_rgb_capture #(
    parameter int unsigned H_ACTIVE         = 480,
    parameter int unsigned V_ACTIVE         = 272,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input logic               in_clk,
    input logic               in_rst,
    lcd_rgb_capture_if.slave  bus
);
    localparam logic [9:0] HACT  = 10'(H_ACTIVE);
    localparam logic [9:0] VACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HLAST = 10'(H_ACTIVE - 1);

    typedef enum logic [0:0] {StSeek, StFrame} state_e;
    state_e state_q, state_d;

    logic        de_q, de_prev_q, vs_q, vs_prev_q;
    logic [15:0] rgb_q;
    logic [9:0]  x_q, x_d, y_q, y_d, lines_q, lines_d;
    logic        err_flag_q, err_flag_d;
    logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic        err_w_q, err_w_d, err_h_q, err_h_d, locked_q, locked_d;
    logic [9:0]  px_q, px_d, py_q, py_d;
    logic [15:0] orgb_q, orgb_d, frames_q, frames_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [8:0]  err_sum;
    logic        vs_edge, de_fall;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // XOR with the polarity bit turns the raw level into "asserted".
    assign vs_edge = (vs_q ^ VSYNC_ACTIVE_LOW) & ~(vs_prev_q ^ VSYNC_ACTIVE_LOW);
    assign de_fall = de_prev_q & ~de_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= StSeek;
            de_q       <= 1'b0;
            de_prev_q  <= 1'b0;
            vs_q       <= VSYNC_ACTIVE_LOW;
            vs_prev_q  <= VSYNC_ACTIVE_LOW;
            rgb_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            lines_q    <= '0;
            err_flag_q <= 1'b0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            err_w_q    <= 1'b0;
            err_h_q    <= 1'b0;
            locked_q   <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            orgb_q     <= '0;
            err_cnt_q  <= '0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            de_q       <= bus.in_en;
            de_prev_q  <= de_q;
            vs_q       <= bus.in_vsync;
            vs_prev_q  <= vs_q;
            rgb_q      <= {bus.in_r, bus.in_g, bus.in_b};
            x_q        <= x_d;
            y_q        <= y_d;
            lines_q    <= lines_d;
            err_flag_q <= err_flag_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            err_w_q    <= err_w_d;
            err_h_q    <= err_h_d;
            locked_q   <= locked_d;
            px_q       <= px_d;
            py_q       <= py_d;
            orgb_q     <= orgb_d;
            err_cnt_q  <= err_cnt_d;
            frames_q   <= frames_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        lines_d    = lines_q;
        err_flag_d = err_flag_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        err_w_d    = 1'b0;
        err_h_d    = 1'b0;
        locked_d   = locked_q;
        px_d       = px_q;
        py_d       = py_q;
        orgb_d     = orgb_q;
        err_cnt_d  = err_cnt_q;
        frames_d   = frames_q;
        err_sum    = '0;

        unique case (state_q)
            StSeek: begin
                if (vs_edge) begin
                    x_d        = '0;
                    y_d        = '0;
                    lines_d    = '0;
                    err_flag_d = 1'b0;
                    state_d    = StFrame;
                end
            end
            StFrame: begin
                if (de_fall) begin
                    err_w_d = (x_q != HACT);
                    x_d     = '0;
                    y_d     = sat_inc(y_q);
                    lines_d = sat_inc(lines_q);
                end
                // A line ending on the VSYNC edge still counts toward the closing frame.
                if (vs_edge) begin
                    err_h_d = (lines_d != VACT);
                    if (!err_h_d && !err_w_d && !err_flag_q) begin
                        frames_d = frames_q + 16'd1;
                        locked_d = 1'b1;
                    end
                    x_d     = '0;
                    y_d     = '0;
                    lines_d = '0;
                end else if (de_q) begin
                    if (x_q < HACT && y_q < VACT) begin
                        valid_d = 1'b1;
                        px_d    = x_q;
                        py_d    = y_q;
                        orgb_d  = rgb_q;
                        sof_d   = (x_q == 10'd0) && (y_q == 10'd0);
                        eol_d   = (x_q == HLAST);
                    end
                    x_d = sat_inc(x_q);
                end
                if (err_w_d || err_h_d) begin
                    locked_d   = 1'b0;
                    err_flag_d = 1'b1;
                    err_sum    = {1'b0, err_cnt_q} + 9'(err_w_d) + 9'(err_h_d);
                    err_cnt_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
                end
                if (vs_edge) begin
                    err_flag_d = 1'b0;
                end
            end
            default: state_d = StSeek;
        endcase
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_sof        = sof_q;
    assign bus.out_eol        = eol_q;
    assign bus.out_pixelx     = px_q;
    assign bus.out_pixely     = py_q;
    assign bus.out_rgb        = orgb_q;
    assign bus.out_locked     = locked_q;
    assign bus.out_err_width  = err_w_q;
    assign bus.out_err_height = err_h_q;
    assign bus.out_err_count  = err_cnt_q;
    assign bus.out_frames     = frames_q;
endmodule

// File: tb/tb_lcd_rgb_capture.sv
// Bench for lcd_rgb_capture: directed scenarios plus random frames, every cycle compared
// against a behavioural model of the capture rules running on the sampled input stream.
module tb_lcd_rgb_capture;
    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_rgb_capture_if bus();

    lcd_rgb_capture #(
        .H_ACTIVE        (H),
        .V_ACTIVE        (V),
        .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .in_clk(clk),
        .in_rst(rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: plain integers, driven by what the block saw one edge earlier.
    bit m_seek = 1'b1;
    int mx = 0, my = 0, mlines = 0, mlocked = 0, merrs = 0, mframes = 0;
    bit mbad = 1'b0;
    bit s1_en = 1'b0, s1_vsa = 1'b0, p_en = 1'b0, p_vsa = 1'b0;
    logic [15:0] s1_rgb = '0;
    bit e_valid = 0, e_sof = 0, e_eol = 0, e_ew = 0, e_eh = 0;
    int e_px = 0, e_py = 0;
    logic [15:0] e_rgb = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_seek = 1'b1; mx = 0; my = 0; mlines = 0; mbad = 1'b0;
            mlocked = 0; merrs = 0; mframes = 0;
            s1_en = 0; s1_vsa = 0; p_en = 0; p_vsa = 0; s1_rgb = '0;
            e_valid = 0; e_sof = 0; e_eol = 0; e_ew = 0; e_eh = 0;
            e_px = 0; e_py = 0; e_rgb = '0;
        end else begin
            bit vs_edge, de_fall;
            int nerr;
            vs_edge = s1_vsa && !p_vsa;
            de_fall = p_en && !s1_en;
            e_valid = 0; e_sof = 0; e_eol = 0; e_ew = 0; e_eh = 0;
            if (m_seek) begin
                if (vs_edge) begin
                    m_seek = 1'b0; mx = 0; my = 0; mlines = 0; mbad = 1'b0;
                end
            end else begin
                if (de_fall) begin
                    e_ew = (mx != H);
                    mx = 0;
                    my = (my + 1 > 1023) ? 1023 : my + 1;
                    mlines = (mlines + 1 > 1023) ? 1023 : mlines + 1;
                end
                if (vs_edge) begin
                    e_eh = (mlines != V);
                    if (!e_eh && !e_ew && !mbad) begin
                        mframes = (mframes + 1) % 65536;
                        mlocked = 1;
                    end
                    mx = 0; my = 0; mlines = 0;
                end else if (s1_en) begin
                    if (mx < H && my < V) begin
                        e_valid = 1; e_px = mx; e_py = my; e_rgb = s1_rgb;
                        e_sof = (mx == 0 && my == 0);
                        e_eol = (mx == H - 1);
                    end
                    mx = (mx + 1 > 1023) ? 1023 : mx + 1;
                end
                nerr = int'(e_ew) + int'(e_eh);
                if (nerr > 0) begin
                    mlocked = 0;
                    merrs = (merrs + nerr > 255) ? 255 : merrs + nerr;
                    mbad = 1'b1;
                end
                if (vs_edge) mbad = 1'b0;
            end
            p_en = s1_en;
            p_vsa = s1_vsa;
            s1_en = bus.in_en;
            s1_vsa = !bus.in_vsync;
            s1_rgb = {bus.in_r, bus.in_g, bus.in_b};
        end
    end

    int cnt_valid = 0, cnt_sof = 0, cnt_eol = 0, cnt_ew = 0, cnt_eh = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid", bus.out_valid, e_valid);
            check("sof", bus.out_sof, e_sof);
            check("eol", bus.out_eol, e_eol);
            check("err_width", bus.out_err_width, e_ew);
            check("err_height", bus.out_err_height, e_eh);
            check("locked", bus.out_locked, mlocked);
            check("err_count", bus.out_err_count, merrs);
            check("frames", bus.out_frames, mframes);
            if (e_valid) begin
                check("pixelx", bus.out_pixelx, e_px);
                check("pixely", bus.out_pixely, e_py);
                check("rgb", bus.out_rgb, e_rgb);
            end
            if (bus.out_valid === 1'b1) cnt_valid++;
            if (bus.out_sof === 1'b1) cnt_sof++;
            if (bus.out_eol === 1'b1) cnt_eol++;
            if (bus.out_err_width === 1'b1) cnt_ew++;
            if (bus.out_err_height === 1'b1) cnt_eh++;
        end
    end

    task automatic clr_counts();
        cnt_valid = 0; cnt_sof = 0; cnt_eol = 0; cnt_ew = 0; cnt_eh = 0;
    endtask

    task automatic cyc(input logic en, input logic vsa, input logic [15:0] rgb);
        bus.in_en    = en;
        bus.in_vsync = ~vsa;
        bus.in_hsync = 1'($urandom);
        {bus.in_r, bus.in_g, bus.in_b} = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic vs_pulse();
        cyc(1'b0, 1'b1, 16'($urandom));
        cyc(1'b0, 1'b1, 16'($urandom));
        idle(3);
    endtask

    task automatic line(input int w);
        for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, 16'($urandom));
        idle(4);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) line(H);
    endtask

    initial begin
        bus.in_en = 1'b0; bus.in_vsync = 1'b1; bus.in_hsync = 1'b0;
        bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_locked", bus.out_locked, 0);
        check("rst_err_count", bus.out_err_count, 0);
        check("rst_frames", bus.out_frames, 0);
        check("rst_pixelx", bus.out_pixelx, 0);
        check("rst_rgb", bus.out_rgb, 0);
        rst = 1'b0;
        idle(3);

        // Three clean frames.
        for (int f = 0; f < 3; f++) begin
            clr_counts();
            vs_pulse();
            lines(V);
            check("frame_valid_count", cnt_valid, 32);
            check("frame_sof_count", cnt_sof, 1);
            check("frame_eol_count", cnt_eol, 4);
        end
        check("clean_frames", bus.out_frames, 2);
        check("clean_locked", bus.out_locked, 1);
        check("clean_err_count", bus.out_err_count, 0);
        check("model_frames", mframes, 2);

        // Latency and data pass-through.
        vs_pulse();
        cyc(1'b1, 1'b0, 16'hF81F);
        check("lat_not_yet", bus.out_valid, 0);
        cyc(1'b1, 1'b0, 16'h0000);
        check("lat_valid", bus.out_valid, 1);
        check("lat_pixelx", bus.out_pixelx, 0);
        check("lat_rgb", bus.out_rgb, 16'hF81F);
        repeat (6) cyc(1'b1, 1'b0, 16'($urandom));
        idle(4);
        lines(V - 1);

        // One over-long line.
        vs_pulse();
        check("pre_width_frames", bus.out_frames, 4);
        clr_counts();
        line(9);
        check("width_valid_count", cnt_valid, 8);
        check("width_pulse", cnt_ew, 1);
        check("width_locked", bus.out_locked, 0);
        check("width_err_count", bus.out_err_count, 1);
        lines(V - 1);
        vs_pulse();
        check("bad_frame_not_counted", bus.out_frames, 4);
        lines(V);
        vs_pulse();
        check("relock_frames", bus.out_frames, 5);
        check("relock_locked", bus.out_locked, 1);

        // Short frame.
        lines(3);
        clr_counts();
        vs_pulse();
        check("height_pulse", cnt_eh, 1);
        check("height_locked", bus.out_locked, 0);
        check("height_frames", bus.out_frames, 5);
        check("height_err_count", bus.out_err_count, 2);
        lines(V);

        // VSYNC edge on a DE cycle drops that pixel.
        cyc(1'b1, 1'b1, 16'hDEAD);
        cyc(1'b1, 1'b1, 16'h1111);
        check("coin_dropped", bus.out_valid, 0);
        cyc(1'b1, 1'b0, 16'h2222);
        check("coin_valid", bus.out_valid, 1);
        check("coin_pixelx", bus.out_pixelx, 0);
        check("coin_pixely", bus.out_pixely, 0);
        check("coin_sof", bus.out_sof, 1);
        check("coin_rgb", bus.out_rgb, 16'h1111);
        repeat (6) cyc(1'b1, 1'b0, 16'($urandom));
        idle(4);
        check("coin_frames", bus.out_frames, 6);
        check("coin_locked", bus.out_locked, 1);
        lines(V - 1);

        // Reset in the middle of a line.
        repeat (3) cyc(1'b1, 1'b0, 16'($urandom));
        rst = 1'b1;
        cyc(1'b1, 1'b0, 16'($urandom));
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_locked", bus.out_locked, 0);
        check("mid_rst_frames", bus.out_frames, 0);
        check("mid_rst_err_count", bus.out_err_count, 0);
        check("mid_rst_rgb", bus.out_rgb, 0);
        rst = 1'b0;
        clr_counts();
        repeat (4) cyc(1'b1, 1'b0, 16'($urandom));
        idle(4);
        lines(2);
        check("seek_no_valid", cnt_valid, 0);
        vs_pulse();
        check("post_rst_first_vs", bus.out_frames, 0);
        lines(V);
        check("post_rst_valid", cnt_valid, 32);
        vs_pulse();
        check("post_rst_second_vs", bus.out_frames, 1);
        check("post_rst_locked", bus.out_locked, 1);

        // Random frames: widths, line counts, gaps and coincident VSYNC edges.
        for (int f = 0; f < 10; f++) begin
            int nl;
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'b1, 1'b1, 16'($urandom));
                line(H);
                nl = int'($urandom_range(2, 4));
            end else begin
                vs_pulse();
                nl = int'($urandom_range(3, 5));
            end
            for (int l = 0; l < nl; l++) begin
                int w;
                w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 10)) : H;
                for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, 16'($urandom));
                idle(int'($urandom_range(1, 5)));
            end
        end
        vs_pulse();
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
